// File: rtl/iob_regfile_arb_pkg.sv
// rtl/iob_regfile_arb_pkg.sv - shared state encodings and grant-index width for the register-file arbiter
package iob_regfile_arb_pkg;

  // Largest supported requester count; sets the width of every grant index.
  localparam int MAX_REQ     = 8;
  localparam int GRANT_IDX_W = $clog2(MAX_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/iob_rr_arbiter.sv
// rtl/iob_rr_arbiter.sv - combinational round-robin grant starting after the last winner
module iob_rr_arbiter
  import iob_regfile_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]       req_i,
  input  logic [GRANT_IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [GRANT_IDX_W-1:0] grant_idx_o,
  output logic                   grant_valid_o
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  int                 shamt;
  int                 sum;

  // Rotate requests so bit 0 is the requester after last_grant, then take the lowest set bit.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    sum           = 0;
    shamt         = int'(last_grant_i) + 1;
    req_dbl       = {req_i, req_i} >> shamt;
    req_rot       = req_dbl[N_REQ-1:0];
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_valid_o && req_rot[j]) begin
        grant_valid_o = 1'b1;
        sum           = int'(last_grant_i) + 1 + j;
        if (sum >= N_REQ) begin
          sum = sum - N_REQ;
        end
        grant_idx_o = GRANT_IDX_W'(sum);
        grant_o     = N_REQ'(1) << grant_idx_o;
      end
    end
  end

endmodule

// File: rtl/iob_regfile_arbiter.sv
// rtl/iob_regfile_arbiter.sv - round-robin register-file arbiter; clear sequencer under IOB_REGFILE_ARB_CLR_EN
module iob_regfile_arbiter
  import iob_regfile_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [N_REQ*NUM_COL-1:0]      req_wstrb,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic [ADDR_WIDTH-1:0]         rf_addr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [NUM_COL-1:0]            rf_en,
  input  logic [DATA_WIDTH-1:0]         rf_rdata,
  input  logic                          clr,
  output logic                          clr_done,
  output logic                          busy
);

  logic [N_REQ-1:0]       grant_vec;
  logic [GRANT_IDX_W-1:0] grant_idx;
  logic                   grant_any;
  logic                   grant_en;
  logic                   accept;
  logic                   clearing;
  logic [ADDR_WIDTH-1:0]  clr_addr;
  logic [GRANT_IDX_W-1:0] last_grant_q;
  logic [N_REQ-1:0]       resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_rdata_q;

`ifdef IOB_REGFILE_ARB_CLR_EN
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  clr_done_q;
  logic                  busy_q;

  // Clear sequencer: walk every address once, flag the final write with clr_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b1;
            clr_done_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            clr_done_q <= ((clr_cnt_q + 1'b1) == CLR_LAST);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A clr request in IDLE wins over any pending request that cycle.
  assign grant_en = (state_q == ST_IDLE) && !clr;
  assign clearing = (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign grant_en   = 1'b1;
  assign clearing   = 1'b0;
  assign clr_addr   = '0;
  assign clr_done   = 1'b0;
  assign busy       = 1'b0;
`endif

  iob_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant_vec),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_any)
  );

  assign accept    = grant_any && grant_en;
  assign req_ready = grant_en ? grant_vec : '0;

  // Register-file port: clear pattern, granted requester, or idle with no enables.
  always_comb begin
    rf_addr  = '0;
    rf_wdata = '0;
    rf_en    = '0;
    if (clearing) begin
      rf_addr  = clr_addr;
      rf_wdata = '0;
      rf_en    = '1;
    end else if (accept) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_vec[i]) begin
          rf_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          rf_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          rf_en    = req_wstrb[i*NUM_COL +: NUM_COL];
        end
      end
    end
  end

  // Response stage: capture pre-write read data on accept, hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= req_ready;
      if (accept) begin
        resp_rdata_q <= rf_rdata;
      end
    end
  end

  // Round-robin pointer: reset so requester 0 wins first, move only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_IDX_W'(N_REQ - 1);
    end else if (accept) begin
      last_grant_q <= grant_idx;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule
